// File: rtl/sobel_pkg.sv
// Shared types and constants for the Sobel pixel fetch path.
// Latency: n/a (types, constants and a pure byte-select helper only).
// Backpressure: n/a.
package sobel_pkg;

    localparam int PIX_W        = 8;
    localparam int WORD_W       = 32;
    localparam int PIX_PER_WORD = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } fetch_state_t;

    // Select one pixel lane of a packed memory word; lane 0 is bits 7:0.
    function automatic logic [PIX_W-1:0] byte_lane(input logic [WORD_W-1:0] word,
                                                   input logic [1:0]        lane);
        return word[lane*PIX_W +: PIX_W];
    endfunction

endpackage

// File: rtl/sobel_fetch_fifo.sv
// Synchronous word FIFO buffering image-memory read data ahead of the unpacker.
// Latency: push visible at the head the cycle after the push; pop_dat is combinational from the head.
// Backpressure: push ignored when full, pop ignored when empty; simultaneous push/pop keeps occupancy.
module sobel_fetch_fifo
    import sobel_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = WORD_W
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [W-1:0]             push_dat,
    input  logic                     pop,
    output logic [W-1:0]             pop_dat,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0]   DEPTH_C = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == DEPTH_C);
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign pop_dat = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Pointer and occupancy update; pointers wrap naturally since DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Control registers; clearing these empties the FIFO, storage contents are don't-care.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Word storage, written at the tail on every accepted push.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_dat;
        end
    end

endmodule

// File: rtl/sobel_pixel_fetch.sv
// Avalon-MM read master fetching packed greyscale words and streaming them as SOP/EOP-framed pixels.
// Latency: first pixel valid 1 (capture) + 1 (issue) + READ_LATENCY cycles after start; data from FIFO head.
// Backpressure: src_ready low holds the pixel; reads issue only while FIFO free slots exceed reads in flight.
// Build option: define SOBEL_FETCH_MSB_FIRST_EN to unpack bits 31:24 first instead of bits 7:0.
module sobel_pixel_fetch
    import sobel_pkg::*;
#(
    parameter int ADDR_W       = 8,
    parameter int FIFO_DEPTH   = 4,
    parameter int READ_LATENCY = 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [ADDR_W:0]     word_count,
    output logic                busy,
    output logic                done,
    output logic [ADDR_W-1:0]   avm_address,
    output logic                avm_chipselect,
    input  logic [WORD_W-1:0]   avm_readdata,
    output logic                src_valid,
    input  logic                src_ready,
    output logic [PIX_W-1:0]    src_data,
    output logic                src_sop,
    output logic                src_eop
);

    localparam int CNT_W     = $clog2(FIFO_DEPTH) + 1;
    localparam int PIX_CNT_W = ADDR_W + 3;

    localparam logic [CNT_W:0]      DEPTH_V   = (CNT_W+1)'(FIFO_DEPTH);
    localparam logic [ADDR_W-1:0]   ADDR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W:0]     WORD_ONE  = (ADDR_W+1)'(1);
    localparam logic [PIX_CNT_W-1:0] PIX_ONE  = PIX_CNT_W'(1);
    localparam logic [1:0]          LAST_LANE = 2'(PIX_PER_WORD - 1);

    fetch_state_t              state_q, state_d;
    logic [ADDR_W-1:0]         addr_q, addr_d;
    logic [ADDR_W:0]           words_left_q, words_left_d;
    logic [PIX_CNT_W-1:0]      pix_left_q, pix_left_d;
    logic [1:0]                pix_idx_q, pix_idx_d;
    logic                      sop_pend_q, sop_pend_d;
    logic [READ_LATENCY-1:0]   rd_pipe_q, rd_pipe_d;

    logic                      fifo_push;
    logic                      fifo_pop;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic [CNT_W-1:0]          fifo_count;
    logic [WORD_W-1:0]         fifo_rdata;

    logic [CNT_W:0]            inflight;
    logic [CNT_W:0]            occupancy;
    logic                      issue;
    logic                      pix_fire;
    logic [1:0]                lane;

    sobel_fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (WORD_W)
    ) u_fifo (
        .clk      (clk),
        .reset_n  (reset_n),
        .push     (fifo_push),
        .push_dat (avm_readdata),
        .pop      (fifo_pop),
        .pop_dat  (fifo_rdata),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    // Reads in flight plus buffered words must stay within FIFO_DEPTH, so the FIFO can never overflow
    // even if the consumer stalls indefinitely; a same-cycle pop is deliberately not credited.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < READ_LATENCY; i++) begin
            inflight = inflight + {{CNT_W{1'b0}}, rd_pipe_q[i]};
        end
        occupancy = {1'b0, fifo_count} + inflight;
        issue     = (state_q == FETCH) && !fifo_full && (occupancy < DEPTH_V);
    end

    // Pixel lane order within a word.
    always_comb begin
`ifdef SOBEL_FETCH_MSB_FIRST_EN
        lane = LAST_LANE - pix_idx_q;
`else
        lane = pix_idx_q;
`endif
    end

    assign src_valid      = !fifo_empty;
    assign src_data       = byte_lane(fifo_rdata, lane);
    assign src_sop        = src_valid && sop_pend_q;
    assign src_eop        = src_valid && (pix_left_q == PIX_ONE);
    assign pix_fire       = src_valid && src_ready;
    assign fifo_pop       = pix_fire && (pix_idx_q == LAST_LANE);
    assign fifo_push      = rd_pipe_q[READ_LATENCY-1];

    assign busy           = (state_q != IDLE);
    assign done           = (state_q == DONE);
    assign avm_address    = addr_q;
    assign avm_chipselect = issue;

    // Next-state: FSM, read address/count tracking, return-flag pipe and pixel counters.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        words_left_d = words_left_q;
        pix_left_d   = pix_left_q;
        pix_idx_d    = pix_idx_q;
        sop_pend_d   = sop_pend_q;

        rd_pipe_d[0] = issue;
        for (int i = 1; i < READ_LATENCY; i++) begin
            rd_pipe_d[i] = rd_pipe_q[i-1];
        end

        if (pix_fire) begin
            pix_idx_d  = pix_idx_q + 2'd1;
            pix_left_d = pix_left_q - PIX_ONE;
            sop_pend_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    addr_d       = base_addr;
                    words_left_d = word_count;
                    pix_left_d   = {word_count, 2'b00};
                    pix_idx_d    = 2'd0;
                    sop_pend_d   = 1'b1;
                    state_d      = (word_count == '0) ? DONE : FETCH;
                end
            end
            FETCH: begin
                if (issue) begin
                    addr_d       = addr_q + ADDR_ONE;
                    words_left_d = words_left_q - WORD_ONE;
                    if (words_left_q == WORD_ONE) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (pix_fire && (pix_left_q == PIX_ONE)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers; reset aborts any frame and drops returning read data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            words_left_q <= '0;
            pix_left_q   <= '0;
            pix_idx_q    <= '0;
            sop_pend_q   <= 1'b0;
            rd_pipe_q    <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            words_left_q <= words_left_d;
            pix_left_q   <= pix_left_d;
            pix_idx_q    <= pix_idx_d;
            sop_pend_q   <= sop_pend_d;
            rd_pipe_q    <= rd_pipe_d;
        end
    end

endmodule

// File: tb/tb_sobel_pixel_fetch.sv
// Self-checking bench for sobel_pixel_fetch: memory model, randomized backpressure, frame-level reference.
// Latency: n/a.
// Backpressure: src_ready driven randomly per frame at a chosen acceptance percentage.
module tb_sobel_pixel_fetch;
    import sobel_pkg::*;

    localparam int ADDR_W = 8;
    localparam int DEPTH  = 4;
    localparam int RL     = 1;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic [ADDR_W:0]   word_count = '0;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] avm_address;
    logic              avm_chipselect;
    logic [31:0]       avm_readdata = '0;
    logic              src_valid;
    logic              src_ready = 1'b0;
    logic [7:0]        src_data;
    logic              src_sop;
    logic              src_eop;

    sobel_pixel_fetch #(
        .ADDR_W       (ADDR_W),
        .FIFO_DEPTH   (DEPTH),
        .READ_LATENCY (RL)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .start          (start),
        .base_addr      (base_addr),
        .word_count     (word_count),
        .busy           (busy),
        .done           (done),
        .avm_address    (avm_address),
        .avm_chipselect (avm_chipselect),
        .avm_readdata   (avm_readdata),
        .src_valid      (src_valid),
        .src_ready      (src_ready),
        .src_data       (src_data),
        .src_sop        (src_sop),
        .src_eop        (src_eop)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Image memory with one cycle of read latency.
    logic [31:0] mem [256];
    always @(posedge clk) begin
        if (avm_chipselect) avm_readdata <= mem[avm_address];
    end

    int cyc = 0;
    always @(posedge clk) cyc++;

    int ready_pct = 100;
    always @(posedge clk) begin
        #1;
        src_ready = (int'($urandom_range(0, 99)) < ready_pct);
    end

    typedef struct {
        logic [7:0] d;
        logic       sop;
        logic       eop;
    } pix_t;

    pix_t       exp_q[$];
    pix_t       mon_e;
    logic [7:0] exp_addr;
    int         issued, accepted, popped_words;
    int         done_cnt, done_cyc, eop_cyc, first_vld_cyc, start_cyc;
    bit         frame_active = 1'b0;
    bit         prev_stall = 1'b0;
    logic [9:0] prev_out;

    // Expected pixel stream of a frame: every word in address order (mod 256), four pixels each.
    function automatic void build_model(input logic [7:0] base, input int cnt);
        logic [31:0] word;
        int          sh;
        pix_t        p;
        for (int w = 0; w < cnt; w++) begin
            word = mem[8'(base + w)];
            for (int b = 0; b < 4; b++) begin
`ifdef SOBEL_FETCH_MSB_FIRST_EN
                sh = 3 - b;
`else
                sh = b;
`endif
                p.d   = word[sh*8 +: 8];
                p.sop = (w == 0) && (b == 0);
                p.eop = (w == cnt - 1) && (b == 3);
                exp_q.push_back(p);
            end
        end
    endfunction

    // Monitor sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (!reset_n) begin
            prev_stall = 1'b0;
        end else begin
            if (avm_chipselect) begin
                if (frame_active) begin
                    chk("rd_addr", avm_address, exp_addr);
                    exp_addr = exp_addr + 8'd1;
                    issued++;
                    chk("words_le_depth", (issued - popped_words <= DEPTH), 1);
                end else begin
                    chk("stray_chipselect", 1, 0);
                end
            end
            if (prev_stall) begin
                chk("hold_valid", src_valid, 1);
                chk("hold_pixel", {src_data, src_sop, src_eop}, prev_out);
            end
            if (src_valid && !frame_active) chk("stray_valid", 1, 0);
            if (src_valid && first_vld_cyc < 0) first_vld_cyc = cyc;
            if (src_valid && src_ready) begin
                if (exp_q.size() == 0) begin
                    chk("extra_pixel", 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("pix_data", src_data, mon_e.d);
                    chk("pix_sop", src_sop, mon_e.sop);
                    chk("pix_eop", src_eop, mon_e.eop);
                    if (src_eop) eop_cyc = cyc;
                end
                accepted++;
                if (accepted % 4 == 0) popped_words++;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                chk("busy_with_done", busy, 1);
            end
            prev_stall = src_valid && !src_ready;
            prev_out   = {src_data, src_sop, src_eop};
        end
    end

    task automatic arm(input logic [7:0] base, input int cnt, input int pct);
        exp_q.delete();
        build_model(base, cnt);
        exp_addr      = base;
        issued        = 0;
        accepted      = 0;
        popped_words  = 0;
        done_cnt      = 0;
        done_cyc      = -1;
        eop_cyc       = -1;
        first_vld_cyc = -1;
        ready_pct     = pct;
    endtask

    task automatic pulse_start(input logic [7:0] base, input int cnt);
        @(posedge clk);
        #1;
        chk("idle_busy", busy, 0);
        frame_active = 1'b1;
        start        = 1'b1;
        base_addr    = base;
        word_count   = 9'(cnt);
        start_cyc    = cyc;
        @(posedge clk);
        #1;
        start      = 1'b0;
        base_addr  = 8'($urandom);
        word_count = 9'($urandom);
        chk("busy_after_start", busy, 1);
    endtask

    task automatic run_frame(input logic [7:0] base, input int cnt, input int pct,
                             input bit retrig, input bit chk_lat);
        int n;
        arm(base, cnt, pct);
        pulse_start(base, cnt);
        if (retrig) begin
            repeat (3) @(posedge clk);
            #1;
            start      = 1'b1;
            base_addr  = 8'($urandom);
            word_count = 9'($urandom_range(1, 256));
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        n = 0;
        while (done_cnt == 0 && n < 3000) begin
            @(posedge clk);
            n++;
        end
        if (done_cnt == 0) chk("done_timeout", 0, 1);
        repeat (4) @(posedge clk);
        #1;
        chk("done_pulses", done_cnt, 1);
        chk("reads_issued", issued, cnt);
        chk("pixels_left", exp_q.size(), 0);
        chk("pixels_accepted", accepted, 4 * cnt);
        if (cnt != 0) chk("done_after_eop", done_cyc - eop_cyc, 1);
        else          chk("done_after_start", done_cyc - start_cyc, 1);
        if (chk_lat)  chk("first_pixel_latency", first_vld_cyc - start_cyc, 2 + RL);
        chk("busy_after_done", busy, 0);
        frame_active = 1'b0;
    endtask

    task automatic chk_outputs_zero(input string pfx);
        chk({pfx, "_busy"}, busy, 0);
        chk({pfx, "_done"}, done, 0);
        chk({pfx, "_cs"}, avm_chipselect, 0);
        chk({pfx, "_addr"}, avm_address, 0);
        chk({pfx, "_valid"}, src_valid, 0);
        chk({pfx, "_sop"}, src_sop, 0);
        chk({pfx, "_eop"}, src_eop, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        mem[8'h10] = 32'h4433_2211;
        mem[8'h11] = 32'h8877_6655;

        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_outputs_zero("reset");
        reset_n = 1'b1;

        // Two-word frame, full throughput, with start-to-first-pixel latency.
        run_frame(8'h10, 2, 100, 1'b0, 1'b1);
        // Address wrap 0xFF -> 0x00.
        run_frame(8'hFE, 4, 100, 1'b0, 1'b1);
        // Random backpressure, ready low about 30% of cycles.
        run_frame(8'($urandom), 16, 70, 1'b0, 1'b0);
        // Empty frame.
        run_frame(8'($urandom), 0, 100, 1'b0, 1'b0);

        // Reset while draining a stalled frame.
        arm(8'h40, 2, 0);
        pulse_start(8'h40, 2);
        n = 0;
        while (issued < 2 && n < 50) begin
            @(posedge clk);
            n++;
        end
        if (issued < 2) chk("drain_issue_timeout", 0, 1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        chk("pre_reset_stalled", src_valid, 1);
        chk("pre_reset_busy", busy, 1);
        #1;
        reset_n = 1'b0;
        #1;
        chk_outputs_zero("midrst");
        frame_active = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        run_frame(8'h10, 2, 100, 1'b0, 1'b1);

        // Start re-pulsed while busy must be ignored.
        run_frame(8'($urandom), 16, 80, 1'b1, 1'b0);

        for (int k = 0; k < 4; k++) begin
            run_frame(8'($urandom), $urandom_range(1, 20), $urandom_range(40, 100), k[0], 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
